// File: rtl/pipe_if_id_skid.sv
// IF/ID pipeline register: valid/ready handshake, hazard stall, branch flush with
// NOP bubble, and an optional 2-entry skid buffer that registers fetch-side ready.
module pipe_if_id_skid #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter int                SKID     = 1,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_npc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [PC_W-1:0]   out_npc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy
);

    logic              main_valid_r, main_valid_s;
    logic [PC_W-1:0]   main_npc_r,   main_npc_s;
    logic [INST_W-1:0] main_inst_r,  main_inst_s;
    logic              skid_valid_r, skid_valid_s;
    logic [PC_W-1:0]   skid_npc_r,   skid_npc_s;
    logic [INST_W-1:0] skid_inst_r,  skid_inst_s;
    logic              in_ready_r,   in_ready_s;
    logic [1:0]        occupancy_r,  occupancy_s;
    logic              ordy_s;
    logic              accept_s;
    logic              consume_s;

    assign ordy_s    = out_ready & ~stall;
    assign in_ready  = (SKID != 0) ? in_ready_r : (~main_valid_r | ordy_s);
    assign accept_s  = in_valid & in_ready;
    assign consume_s = main_valid_r & ordy_s;

    assign out_valid = main_valid_r;
    assign out_npc   = main_npc_r;
    assign out_inst  = main_inst_r;
    assign occupancy = occupancy_r;

    // Next-state for the main/skid entries; an emptied main slot always reads as a NOP bubble.
    always_comb begin
        main_valid_s = main_valid_r;
        main_npc_s   = main_npc_r;
        main_inst_s  = main_inst_r;
        skid_valid_s = skid_valid_r;
        skid_npc_s   = skid_npc_r;
        skid_inst_s  = skid_inst_r;
        if (flush) begin
            main_valid_s = 1'b0;
            main_npc_s   = {PC_W{1'b0}};
            main_inst_s  = NOP_INST;
            skid_valid_s = 1'b0;
            skid_npc_s   = {PC_W{1'b0}};
            skid_inst_s  = {INST_W{1'b0}};
        end else if (SKID != 0) begin
            if (skid_valid_r) begin
                // in_ready is low here, so no accept can land in the same cycle
                if (consume_s) begin
                    main_npc_s   = skid_npc_r;
                    main_inst_s  = skid_inst_r;
                    skid_valid_s = 1'b0;
                    skid_npc_s   = {PC_W{1'b0}};
                    skid_inst_s  = {INST_W{1'b0}};
                end else begin
                    skid_valid_s = skid_valid_r;
                end
            end else if (main_valid_r) begin
                case ({accept_s, consume_s})
                    2'b11: begin
                        main_npc_s  = in_npc;
                        main_inst_s = in_inst;
                    end
                    2'b10: begin
                        skid_valid_s = 1'b1;
                        skid_npc_s   = in_npc;
                        skid_inst_s  = in_inst;
                    end
                    2'b01: begin
                        main_valid_s = 1'b0;
                        main_npc_s   = {PC_W{1'b0}};
                        main_inst_s  = NOP_INST;
                    end
                    default: begin
                        main_valid_s = main_valid_r;
                    end
                endcase
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_npc_s   = in_npc;
                main_inst_s  = in_inst;
            end else begin
                main_valid_s = main_valid_r;
            end
        end else begin
            if (accept_s) begin
                main_valid_s = 1'b1;
                main_npc_s   = in_npc;
                main_inst_s  = in_inst;
            end else if (consume_s) begin
                main_valid_s = 1'b0;
                main_npc_s   = {PC_W{1'b0}};
                main_inst_s  = NOP_INST;
            end else begin
                main_valid_s = main_valid_r;
            end
        end
        in_ready_s  = ~skid_valid_s;
        occupancy_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
    end

    // State registers with asynchronous reset to the empty, ready state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_npc_r   <= {PC_W{1'b0}};
            main_inst_r  <= NOP_INST;
            skid_valid_r <= 1'b0;
            skid_npc_r   <= {PC_W{1'b0}};
            skid_inst_r  <= {INST_W{1'b0}};
            in_ready_r   <= 1'b1;
            occupancy_r  <= 2'd0;
        end else begin
            main_valid_r <= main_valid_s;
            main_npc_r   <= main_npc_s;
            main_inst_r  <= main_inst_s;
            skid_valid_r <= skid_valid_s;
            skid_npc_r   <= skid_npc_s;
            skid_inst_r  <= skid_inst_s;
            in_ready_r   <= in_ready_s;
            occupancy_r  <= occupancy_s;
        end
    end

endmodule
